// File: rtl/core_mem_stage.sv
// core_mem_stage: EX->WB memory stage driving a req/gnt/rvalid data bus, stalling EX during accesses
module core_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [1:0]      i_d_size,
  input  logic            i_d_unsigned,
  input  logic [1:0]      i_mem_to_reg,
  input  logic            i_reg_write,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc_plus_4,
  output logic            o_dmem_req,
  input  logic            i_dmem_gnt,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_valid,
  output logic [1:0]      o_d_size,
  output logic            o_d_unsigned,
  output logic [1:0]      o_mem_to_reg,
  output logic            o_reg_write,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_pc_plus_4,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic            o_misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef struct packed {
    logic [1:0]      d_size;
    logic            d_unsigned;
    logic [1:0]      mem_to_reg;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus_4;
  } wb_t;
  state_t          state_q, state_d;
  wb_t             in_w, cap_q, cap_d, wb_q, wb_d;
  logic            we_q, we_d, wb_valid_q, wb_valid_d, mis_q, mis_d;
  logic [3:0]      be_q, be_d, be_w;
  logic [XLEN-1:0] wdata_q, wdata_d, wdata_w, rd_data_q, rd_data_d;
  logic [1:0]      off_w;
  logic            is_mem_w, mis_w, accept_w;
  assign in_w = '{d_size: i_d_size, d_unsigned: i_d_unsigned, mem_to_reg: i_mem_to_reg,
                  reg_write: i_reg_write, rd_addr: i_rd_addr, alu_result: i_alu_result,
                  imm: i_imm, pc_plus_4: i_pc_plus_4};
  assign off_w    = i_alu_result[1:0];
  assign is_mem_w = i_mem_read | i_mem_write;
  assign mis_w    = is_mem_w & (i_d_size == 2'b00 ? 1'b0 : i_d_size == 2'b01 ? off_w[0] : |off_w);
  assign accept_w = i_valid & o_ready;
  assign be_w     = i_d_size == 2'b00 ? 4'b0001 << off_w : i_d_size == 2'b01 ? 4'b0011 << off_w : 4'b1111;
  assign wdata_w  = i_d_size == 2'b00 ? {4{i_rs2_data[7:0]}} :
                    i_d_size == 2'b01 ? {2{i_rs2_data[15:0]}} : i_rs2_data;
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_d       = wb_q;
    wb_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mis_d      = mis_q;
    case (state_q)
      IDLE: if (accept_w) begin
        if (is_mem_w & ~mis_w) begin
          cap_d   = in_w;
          we_d    = i_mem_write;
          be_d    = be_w;
          wdata_d = wdata_w;
          state_d = REQ;
        end else begin
          wb_d           = in_w;
          wb_d.reg_write = i_reg_write & ~mis_w;
          wb_valid_d     = 1'b1;
          rd_data_d      = '0;
          mis_d          = mis_w;
        end
      end
      REQ: if (i_dmem_gnt) begin
        state_d    = we_q ? IDLE : WAIT;
        wb_d       = we_q ? cap_q : wb_q;
        wb_valid_d = we_q;
        rd_data_d  = we_q ? '0 : rd_data_q;
        mis_d      = we_q ? 1'b0 : mis_q;
      end
      WAIT: if (i_dmem_rvalid) begin
        state_d    = IDLE;
        wb_d       = cap_q;
        wb_valid_d = 1'b1;
        rd_data_d  = i_dmem_rdata >> {cap_q.alu_result[1:0], 3'b000};
        mis_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      rd_data_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      rd_data_q  <= rd_data_d;
      mis_q      <= mis_d;
    end
  end
  assign o_ready        = state_q == IDLE;
  assign o_dmem_req     = state_q == REQ;
  assign o_dmem_we      = o_dmem_req & we_q;
  assign o_dmem_addr    = o_dmem_req ? {cap_q.alu_result[XLEN-1:2], 2'b00} : '0;
  assign o_dmem_be      = o_dmem_req ? be_q : '0;
  assign o_dmem_wdata   = o_dmem_req ? wdata_q : '0;
  assign o_wb_valid     = wb_valid_q;
  assign o_d_size       = wb_q.d_size;
  assign o_d_unsigned   = wb_q.d_unsigned;
  assign o_mem_to_reg   = wb_q.mem_to_reg;
  assign o_reg_write    = wb_q.reg_write;
  assign o_rd_addr      = wb_q.rd_addr;
  assign o_alu_result   = wb_q.alu_result;
  assign o_imm          = wb_q.imm;
  assign o_pc_plus_4    = wb_q.pc_plus_4;
  assign o_data_rd_data = rd_data_q;
  assign o_misaligned   = mis_q;
endmodule

// File: tb/tb_core_mem_stage.sv
// tb_core_mem_stage: directed and randomized checks of core_mem_stage against a byte-lane reference model
module tb_core_mem_stage;
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  m2r;
    logic        rw;
    logic [4:0]  rd_addr;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } ins_t;
  logic        i_clk, i_rst_n, i_valid, o_ready, i_mem_read, i_mem_write;
  logic [1:0]  i_d_size, i_mem_to_reg, o_d_size, o_mem_to_reg;
  logic        i_d_unsigned, i_reg_write, o_d_unsigned, o_reg_write;
  logic [4:0]  i_rd_addr, o_rd_addr;
  logic [31:0] i_alu_result, i_rs2_data, i_imm, i_pc_plus_4;
  logic        o_dmem_req, i_dmem_gnt, o_dmem_we, i_dmem_rvalid, o_wb_valid, o_misaligned;
  logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata, o_alu_result, o_imm, o_pc_plus_4, o_data_rd_data;
  logic [3:0]  o_dmem_be;
  int checks = 0;
  int errors = 0;
  core_mem_stage #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_d_size(i_d_size),
    .i_d_unsigned(i_d_unsigned), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
    .i_rd_addr(i_rd_addr), .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data),
    .i_imm(i_imm), .i_pc_plus_4(i_pc_plus_4), .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_d_size(o_d_size), .o_d_unsigned(o_d_unsigned),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_rd_addr(o_rd_addr),
    .o_alu_result(o_alu_result), .o_imm(o_imm), .o_pc_plus_4(o_pc_plus_4),
    .o_data_rd_data(o_data_rd_data), .o_misaligned(o_misaligned)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int nbytes(input logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction
  function automatic bit is_mis(input ins_t x);
    return (x.rd || x.wr) && (int'(x.alu[1:0]) % nbytes(x.size) != 0);
  endfunction
  function automatic logic [3:0] exp_be(input ins_t x);
    int n = nbytes(x.size);
    int off = int'(x.alu[1:0]);
    return 4'(((1 << n) - 1) << off);
  endfunction
  function automatic logic [31:0] exp_wdata(input ins_t x);
    logic [31:0] w;
    int n = nbytes(x.size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = x.rs2[8*(i % n) +: 8];
    return w;
  endfunction
  task automatic drive(input ins_t x);
    i_valid = 1'b1; i_mem_read = x.rd; i_mem_write = x.wr; i_d_size = x.size;
    i_d_unsigned = x.uns; i_mem_to_reg = x.m2r; i_reg_write = x.rw; i_rd_addr = x.rd_addr;
    i_alu_result = x.alu; i_rs2_data = x.rs2; i_imm = x.imm; i_pc_plus_4 = x.pc4;
  endtask
  task automatic chk_wb(input ins_t x, input logic [31:0] rdata);
    bit mis = is_mis(x);
    chk("wb_valid", o_wb_valid, 1);
    chk("wb_size", o_d_size, x.size);
    chk("wb_uns", o_d_unsigned, x.uns);
    chk("wb_m2r", o_mem_to_reg, x.m2r);
    chk("wb_regwr", o_reg_write, x.rw && !mis);
    chk("wb_rd", o_rd_addr, x.rd_addr);
    chk("wb_alu", o_alu_result, x.alu);
    chk("wb_imm", o_imm, x.imm);
    chk("wb_pc4", o_pc_plus_4, x.pc4);
    chk("wb_mis", o_misaligned, mis);
    chk("wb_rdata", o_data_rd_data, (x.rd && !mis) ? rdata >> (8 * int'(x.alu[1:0])) : 32'h0);
    chk("wb_ready", o_ready, 1);
  endtask
  task automatic run(input ins_t x, input int gd, input int rvd, input logic [31:0] rdata, input bit spurious);
    chk("acc_ready", o_ready, 1);
    drive(x);
    step();
    i_valid = 1'b0;
    if ((x.rd || x.wr) && !is_mis(x)) begin
      for (int k = 0; k <= gd; k++) begin
        chk("req", o_dmem_req, 1);
        chk("req_addr", o_dmem_addr, {x.alu[31:2], 2'b00});
        chk("req_be", o_dmem_be, exp_be(x));
        chk("req_we", o_dmem_we, x.wr);
        if (x.wr) chk("req_wdata", o_dmem_wdata, exp_wdata(x));
        chk("req_ready", o_ready, 0);
        chk("req_wbv", o_wb_valid, 0);
        if (spurious && k == 0 && x.rd) begin
          i_dmem_rvalid = 1'b1;
          i_dmem_rdata = $urandom;
        end
        if (k == gd) i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        i_dmem_rvalid = 1'b0;
      end
      if (x.rd) begin
        for (int j = 0; j < rvd; j++) begin
          chk("wait_req", o_dmem_req, 0);
          chk("wait_ready", o_ready, 0);
          chk("wait_wbv", o_wb_valid, 0);
          step();
        end
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata = rdata;
        step();
        i_dmem_rvalid = 1'b0;
      end
    end else chk("noreq", o_dmem_req, 0);
    chk_wb(x, rdata);
  endtask
  task automatic idle_after(input ins_t x);
    step();
    chk("pulse_end", o_wb_valid, 0);
    chk("hold_rd", o_rd_addr, x.rd_addr);
    chk("hold_alu", o_alu_result, x.alu);
  endtask
  function automatic ins_t mk(input bit rd, input bit wr, input logic [1:0] size, input logic [31:0] alu,
                              input logic [31:0] rs2);
    ins_t x;
    x.rd = rd; x.wr = wr; x.size = size; x.alu = alu; x.rs2 = rs2;
    x.uns = 1'($urandom); x.m2r = 2'($urandom); x.rw = rd | ~wr; x.rd_addr = 5'($urandom);
    x.imm = $urandom; x.pc4 = $urandom;
    return x;
  endfunction
  initial begin
    ins_t x;
    i_rst_n = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_d_size = '0;
    i_d_unsigned = 1'b0; i_mem_to_reg = '0; i_reg_write = 1'b0; i_rd_addr = '0; i_alu_result = '0;
    i_rs2_data = '0; i_imm = '0; i_pc_plus_4 = '0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    i_dmem_rdata = '0;
    step(); step();
    chk("rst_ready", o_ready, 1);
    chk("rst_req", o_dmem_req, 0);
    chk("rst_addr", o_dmem_addr, 0);
    chk("rst_be", o_dmem_be, 0);
    chk("rst_wbv", o_wb_valid, 0);
    chk("rst_rd", o_rd_addr, 0);
    chk("rst_alu", o_alu_result, 0);
    chk("rst_rdata", o_data_rd_data, 0);
    chk("rst_mis", o_misaligned, 0);
    i_rst_n = 1'b1;
    step();
    // three back-to-back ALU ops retire on consecutive cycles
    for (int i = 0; i < 3; i++) begin
      x = mk(0, 0, 2'b11, $urandom, $urandom);
      drive(x);
      step();
      chk("stream_wbv", o_wb_valid, 1);
      chk("stream_rd", o_rd_addr, x.rd_addr);
      chk("stream_alu", o_alu_result, x.alu);
      chk("stream_ready", o_ready, 1);
      chk("stream_req", o_dmem_req, 0);
    end
    i_valid = 1'b0;
    idle_after(x);
    x = mk(0, 1, 2'b00, 32'h103, 32'hAABBCCDD);
    chk("sb_be_model", {28'h0, exp_be(x)}, 32'h8);
    run(x, 0, 0, 0, 0);
    idle_after(x);
    x = mk(1, 0, 2'b01, 32'h202, 32'h0);
    run(x, 3, 1, 32'h8001_1234, 0);
    chk("lh_rdata", o_data_rd_data, 32'h0000_8001);
    idle_after(x);
    x = mk(1, 0, 2'b11, 32'h305, 32'h0);
    run(x, 0, 0, 0, 0);
    idle_after(x);
    x = mk(1, 0, 2'b10, 32'h40C, 32'h0);
    run(x, 2, 0, 32'hCAFE_F00D, 1);
    idle_after(x);
    // reset while waiting for load data
    x = mk(1, 0, 2'b11, 32'h400, 32'h0);
    drive(x);
    step();
    i_valid = 1'b0;
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    chk("w_req", o_dmem_req, 0);
    chk("w_ready", o_ready, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rw_req", o_dmem_req, 0);
    chk("rw_wbv", o_wb_valid, 0);
    chk("rw_ready", o_ready, 1);
    step();
    i_rst_n = 1'b1;
    // reset while requesting a store
    x = mk(0, 1, 2'b11, 32'h500, $urandom);
    drive(x);
    step();
    i_valid = 1'b0;
    chk("rq_req", o_dmem_req, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rr_req", o_dmem_req, 0);
    chk("rr_ready", o_ready, 1);
    step();
    i_rst_n = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata = $urandom;
    step();
    i_dmem_rvalid = 1'b0;
    chk("late_rv_wbv", o_wb_valid, 0);
    chk("late_rv_ready", o_ready, 1);
    x = mk(1, 0, 2'b00, 32'h601, 32'h0);
    run(x, 1, 0, 32'h1122_3344, 0);
    idle_after(x);
    for (int t = 0; t < 60; t++) begin
      int kind = $urandom_range(0, 2);
      logic [1:0] sz = 2'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = a[1:0] & (sz == 2'b00 ? 2'b11 : sz == 2'b01 ? 2'b10 : 2'b00);
      x = mk(kind == 1, kind == 2, sz, a, $urandom);
      run(x, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_after(x);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
